// File: rtl/ioctl_loader_wide.sv
// Host-word to ioctl beat serializer: unpacks 32-bit host words into 8- or
// 16-bit ioctl writes, with length limiting, sink back-pressure and an inter-word gap.
module ioctl_loader_wide #(
  parameter int WIDE   = 0,
  parameter int ADDR_W = 27,
  parameter int SIZE_W = 24,
  parameter int WR_GAP = 1
) (
  input  logic                           clk_sys,
  input  logic                           reset_n,
  input  logic [31:0]                    host_bootdata,
  input  logic                           host_bootdata_req,
  output logic                           host_bootdata_ack,
  input  logic                           host_bootdata_download,
  input  logic [SIZE_W-1:0]              host_bootdata_size,
  input  logic [2:0]                     host_file_type,
  output logic                           ioctl_download,
  output logic [15:0]                    ioctl_index,
  output logic                           ioctl_wr,
  output logic [ADDR_W-1:0]              ioctl_addr,
  output logic [((WIDE != 0) ? 15 : 7):0] ioctl_dout,
  input  logic                           ioctl_wait,
  output logic                           load_done,
  output logic                           load_trunc
);

  localparam int         BPB       = (WIDE != 0) ? 2 : 1;
  localparam int         LANES     = 4 / BPB;
  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);
  localparam logic [3:0] GAP_LAST  = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAITREQ, S_EMIT, S_GAP, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              dl_low_q;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] count_q, count_d;
  logic [2:0]        type_q, type_d;
  logic              dl_q, dl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              trunc_q, trunc_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        lane_q, lane_d;
  logic              phase_q, phase_d;
  logic [3:0]        gap_q, gap_d;
  logic              ack_q, ack_d;

  logic strobe, size_hit, last_lane;

  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Each beat takes a setup cycle (phase 0) and a strobe cycle (phase 1),
  // which keeps ioctl_wr from ever firing on back-to-back cycles.
  assign strobe    = (state_q == S_EMIT) && phase_q && !ioctl_wait;
  assign size_hit  = (size_q != '0) && ((size_q - count_q) <= SIZE_W'(BPB));
  assign last_lane = (lane_q == LAST_LANE);

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    size_d  = size_q;
    count_d = count_q;
    type_d  = type_q;
    dl_d    = dl_q;
    addr_d  = addr_q;
    trunc_d = trunc_q;
    data_d  = data_q;
    lane_d  = lane_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host_bootdata_download && dl_low_q) begin
          state_d = S_WAITREQ;
          size_d  = host_bootdata_size;
          type_d  = host_file_type;
          dl_d    = 1'b1;
          addr_d  = '0;
          count_d = '0;
          trunc_d = 1'b0;
        end
      end
      S_WAITREQ: begin
        if (!host_bootdata_download) begin
          state_d = S_FINISH;
        end else if (host_bootdata_req) begin
          if ((size_q != '0) && (count_q == size_q)) begin
            trunc_d = 1'b1;
            state_d = S_FINISH;
          end else begin
            data_d  = host_bootdata;
            ack_d   = 1'b1;
            lane_d  = 2'd0;
            phase_d = 1'b0;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (strobe) begin
          addr_d  = addr_q + ADDR_W'(BPB);
          count_d = size_hit ? size_q : count_q + SIZE_W'(BPB);
          lane_d  = lane_q + 2'd1;
          phase_d = 1'b0;
          // Hitting the size limit mid-word drops the remaining lanes; hitting it on
          // the last lane still returns to WAITREQ so an extra host word can be flagged.
          if (size_hit && !last_lane) begin
            state_d = S_FINISH;
          end else if (last_lane) begin
            if (!host_bootdata_download) begin
              state_d = S_FINISH;
            end else if (WR_GAP == 0) begin
              state_d = S_WAITREQ;
            end else begin
              gap_d   = 4'd0;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (!host_bootdata_download) begin
          state_d = S_FINISH;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_WAITREQ;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d == S_FINISH) dl_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      dl_low_q <= 1'b0;
      size_q   <= '0;
      count_q  <= '0;
      type_q   <= '0;
      dl_q     <= 1'b0;
      addr_q   <= '0;
      trunc_q  <= 1'b0;
      data_q   <= '0;
      lane_q   <= '0;
      phase_q  <= 1'b0;
      gap_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dl_low_q <= ~host_bootdata_download;
      size_q   <= size_d;
      count_q  <= count_d;
      type_q   <= type_d;
      dl_q     <= dl_d;
      addr_q   <= addr_d;
      trunc_q  <= trunc_d;
      data_q   <= data_d;
      lane_q   <= lane_d;
      phase_q  <= phase_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
    end
  end

  assign host_bootdata_ack = ack_q;
  assign ioctl_download    = dl_q;
  assign ioctl_index       = {13'b0, type_q};
  assign ioctl_wr          = strobe;
  assign ioctl_addr        = addr_q;
  assign load_done         = (state_q == S_FINISH);
  assign load_trunc        = trunc_q;

  if (WIDE != 0) begin : g_wide
    logic odd_tail;
    always_comb begin
      odd_tail   = size_hit && ((size_q - count_q) == SIZE_W'(1));
      ioctl_dout = {odd_tail ? 8'h00 : byte_at(data_q, {lane_q[0], 1'b1}),
                    byte_at(data_q, {lane_q[0], 1'b0})};
    end
  end else begin : g_narrow
    assign ioctl_dout = byte_at(data_q, lane_q);
  end

endmodule
